dcw_multi_channel: RTL and testbench

//  Multi-channel data channel wrapper for the BERT datapath: per channel, a reset sequencer, a datawidth select and a reference-tick generator.

---
 rtl/dcw_multi_channel.sv | 215 +++++++++++++++++++++
 tb/tb_dcw_multi_channel.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcw_multi_channel.sv
// -----------------------------------------------------------------------------
// dcw_multi_channel
//
// Multi-channel data channel wrapper for the BERT datapath. Each of NCH
// channels has its own reset sequencer (OFF/HOLD/RUN), a latched datawidth
// code and a phase-accumulator reference-tick generator. Commands arrive on a
// valid/ready bus, one per cycle at most. Only clock enables are produced;
// no derived clocks leave this block.
//
// Ports
//   clock          in   1          single clock, rising edge
//   reset_n        in   1          asynchronous active-low reset
//   cmd_valid      in   1          command strobe
//   cmd_ready      out  1          1 = command accepted when cmd_valid=1
//   cmd_ch         in   CH_W       target channel
//   cmd_op         in   2          0 STOP, 1 RESET, 2 RUN width A, 3 RUN width B
//   cmd_width_a    in   DW_W       width used by op 2
//   cmd_width_b    in   DW_W       width used by op 3
//   cmd_fcw        in   ACC_W      frequency control word (0 = bypass)
//   cmd_err        out  1          1-cycle pulse: cmd_ch >= NCH, command dropped
//   channel_reset  out  NCH        per-channel lane reset, active high
//   datawidth      out  NCH*DW_W   ch k at [k*DW_W +: DW_W]
//   ref_en         out  NCH        per-channel reference tick (1-cycle pulses)
//   ref_phase      out  NCH        accumulator MSB
//   ch_running     out  NCH        1 = channel in RUN
// -----------------------------------------------------------------------------
module dcw_multi_channel #(
    parameter int NCH        = 4,
    parameter int ACC_W      = 25,
    parameter int DW_W       = 3,
    parameter int RST_CYCLES = 16,
    parameter int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic [1:0]            cmd_op,
    input  logic [DW_W-1:0]       cmd_width_a,
    input  logic [DW_W-1:0]       cmd_width_b,
    input  logic [ACC_W-1:0]      cmd_fcw,
    output logic                  cmd_err,
    output logic [NCH-1:0]        channel_reset,
    output logic [NCH*DW_W-1:0]   datawidth,
    output logic [NCH-1:0]        ref_en,
    output logic [NCH-1:0]        ref_phase,
    output logic [NCH-1:0]        ch_running
);

    typedef enum logic [1:0] {ST_OFF, ST_HOLD, ST_RUN} state_t;
    typedef enum logic [1:0] {OP_STOP, OP_RESET, OP_RUN_A, OP_RUN_B} op_t;

    localparam int              CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    logic            r_cmd_ready;
    logic            r_cmd_err;
    logic            w_accept;
    logic            w_ch_ok;
    op_t             w_op;
    logic [DW_W-1:0] w_sel_width;

    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_ch_ok     = (int'(cmd_ch) < NCH);
    assign w_op        = op_t'(cmd_op);
    assign w_sel_width = cmd_op[0] ? cmd_width_b : cmd_width_a;

    // Command-bus side: ready rises on the first edge after reset release and
    // stays high; an out-of-range channel only raises the error pulse.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_ready <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cmd_ready <= 1'b1;
            r_cmd_err   <= w_accept & ~w_ch_ok;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign cmd_err   = r_cmd_err;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_cfg_valid;
        logic [DW_W-1:0]  r_width;
        logic [ACC_W-1:0] r_fcw;
        logic [ACC_W-1:0] r_fcw_next;
        logic             r_pend;
        logic [ACC_W-1:0] r_acc;
        logic             r_ref_en;
        logic             r_ref_phase;
        logic             r_ch_rst;
        logic             r_running;

        logic             w_hit;
        logic             w_same;
        logic             w_stop;
        logic             w_cfg;
        logic             w_hold;
        logic             w_retune;
        logic             w_carry;
        logic [ACC_W-1:0] w_sum;

        // A RUN command with the width already in use is a retune and keeps
        // the lane out of reset; any width change forces a lane re-reset.
        assign w_hit    = w_accept && (cmd_ch == CH_W'(k));
        assign w_same   = (r_state == ST_RUN) && (w_sel_width == r_width);
        assign w_stop   = w_hit && (w_op == OP_STOP);
        assign w_cfg    = w_hit && cmd_op[1] && !w_same;
        assign w_hold   = w_cfg || (w_hit && (w_op == OP_RESET));
        assign w_retune = w_hit && cmd_op[1] && w_same;

        assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_fcw};

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_state     <= ST_OFF;
                r_cnt       <= '0;
                r_cfg_valid <= 1'b0;
                r_width     <= '0;
                r_fcw       <= '0;
                r_fcw_next  <= '0;
                r_pend      <= 1'b0;
                r_acc       <= '0;
                r_ref_en    <= 1'b0;
                r_ref_phase <= 1'b0;
                r_ch_rst    <= 1'b1;
                r_running   <= 1'b0;
            end else if (w_stop || w_hold) begin
                // Leaving (or restarting) the sequence: tick generator is
                // silenced and a retune still waiting for a carry is folded
                // in, since there is no running period left to protect.
                r_acc       <= '0;
                r_ref_en    <= 1'b0;
                r_ref_phase <= 1'b0;
                r_ch_rst    <= 1'b1;
                r_running   <= 1'b0;
                if (r_pend) begin
                    r_fcw  <= r_fcw_next;
                    r_pend <= 1'b0;
                end
                if (w_stop) begin
                    r_state <= ST_OFF;
                end else begin
                    r_state <= ST_HOLD;
                    r_cnt   <= CNT_LOAD;
                end
                // A fresh configuration overrides any folded-in retune.
                if (w_cfg) begin
                    r_width     <= w_sel_width;
                    r_fcw       <= cmd_fcw;
                    r_cfg_valid <= 1'b1;
                end
            end else begin
                // NOTE: paths that assign nothing simply hold the register;
                // inside a clocked block this is a flop enable, not a latch.
                case (r_state)
                    ST_HOLD: begin
                        if (r_cnt == '0) begin
                            if (r_cfg_valid) begin
                                r_state   <= ST_RUN;
                                r_ch_rst  <= 1'b0;
                                r_running <= 1'b1;
                                // Bypass ticks on every RUN cycle, including the first.
                                r_ref_en  <= (r_fcw == '0);
                            end else begin
                                r_state <= ST_OFF;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (r_fcw == '0) begin
                            r_acc       <= '0;
                            r_ref_en    <= 1'b1;
                            r_ref_phase <= 1'b0;
                        end else begin
                            r_acc       <= w_sum;
                            r_ref_en    <= w_carry;
                            r_ref_phase <= w_sum[ACC_W-1];
                            // Pending fcw takes over only at a wrap so the
                            // current tick period is never shortened.
                            if (w_carry && r_pend) begin
                                r_fcw  <= r_fcw_next;
                                r_pend <= 1'b0;
                            end
                        end
                        if (w_retune) begin
                            if (r_fcw == '0) begin
                                r_fcw <= cmd_fcw;
                            end else begin
                                r_fcw_next <= cmd_fcw;
                                r_pend     <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign channel_reset[k]             = r_ch_rst;
        assign datawidth[k*DW_W +: DW_W]    = r_width;
        assign ref_en[k]                    = r_ref_en;
        assign ref_phase[k]                 = r_ref_phase;
        assign ch_running[k]                = r_running;
    end

endmodule

// File: tb/tb_dcw_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_dcw_multi_channel
//
// Self-checking bench for dcw_multi_channel (NCH=3, ACC_W=8, DW_W=3,
// RST_CYCLES=4). A behavioural per-channel model (mode, remaining reset
// cycles, integer accumulator mod 2^ACC_W) predicts every output each cycle.
// Directed scenarios are followed by randomized command traffic.
// -----------------------------------------------------------------------------
module tb_dcw_multi_channel;

    localparam int NCH        = 3;
    localparam int ACC_W      = 8;
    localparam int DW_W       = 3;
    localparam int RST_CYCLES = 4;
    localparam int CH_W       = 2;
    localparam int MOD        = 1 << ACC_W;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [CH_W-1:0]     cmd_ch = '0;
    logic [1:0]          cmd_op = '0;
    logic [DW_W-1:0]     cmd_width_a = '0;
    logic [DW_W-1:0]     cmd_width_b = '0;
    logic [ACC_W-1:0]    cmd_fcw = '0;
    logic                cmd_err;
    logic [NCH-1:0]      channel_reset;
    logic [NCH*DW_W-1:0] datawidth;
    logic [NCH-1:0]      ref_en;
    logic [NCH-1:0]      ref_phase;
    logic [NCH-1:0]      ch_running;

    always #5 clock = ~clock;

    dcw_multi_channel #(
        .NCH(NCH), .ACC_W(ACC_W), .DW_W(DW_W), .RST_CYCLES(RST_CYCLES), .CH_W(CH_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_op(cmd_op),
        .cmd_width_a(cmd_width_a), .cmd_width_b(cmd_width_b),
        .cmd_fcw(cmd_fcw), .cmd_err(cmd_err),
        .channel_reset(channel_reset), .datawidth(datawidth),
        .ref_en(ref_en), .ref_phase(ref_phase), .ch_running(ch_running)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = lane held off, 1 = timed reset window, 2 = active
    int m_mode[NCH];
    int m_hold_left[NCH];
    bit m_cfg[NCH];
    int m_w[NCH];
    int m_fcw[NCH];
    int m_next[NCH];
    bit m_pend[NCH];
    int m_acc[NCH];
    bit m_ref_en[NCH];
    bit m_phase[NCH];
    bit m_ready;
    bit m_err;

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_mode[k] = 0; m_hold_left[k] = 0; m_cfg[k] = 0; m_w[k] = 0;
            m_fcw[k] = 0; m_next[k] = 0; m_pend[k] = 0; m_acc[k] = 0;
            m_ref_en[k] = 0; m_phase[k] = 0;
        end
        m_ready = 0;
        m_err   = 0;
    endfunction

    function automatic void model_leave(int k);
        m_acc[k] = 0; m_ref_en[k] = 0; m_phase[k] = 0;
        if (m_pend[k]) begin
            m_fcw[k]  = m_next[k];
            m_pend[k] = 0;
        end
    endfunction

    function automatic void model_edge(bit v, int ch, int op, int wa, int wb, int fcw);
        bit acc;
        bit hit;
        bit same;
        int w;
        int old_fcw;
        int s;
        acc     = v && m_ready;
        m_err   = acc && (ch >= NCH);
        m_ready = 1;
        w       = (op % 2 == 1) ? wb : wa;
        for (int k = 0; k < NCH; k++) begin
            hit  = acc && (ch == k);
            same = (m_mode[k] == 2) && (w == m_w[k]);
            if (hit && op == 0) begin
                model_leave(k);
                m_mode[k] = 0;
            end else if (hit && (op == 1 || !same)) begin
                model_leave(k);
                if (op >= 2) begin
                    m_w[k] = w; m_fcw[k] = fcw; m_cfg[k] = 1;
                end
                m_mode[k]      = 1;
                m_hold_left[k] = RST_CYCLES;
            end else if (m_mode[k] == 1) begin
                if (m_hold_left[k] == 1) begin
                    if (m_cfg[k]) begin
                        m_mode[k]   = 2;
                        m_acc[k]    = 0;
                        m_phase[k]  = 0;
                        m_ref_en[k] = (m_fcw[k] == 0);
                    end else begin
                        m_mode[k] = 0;
                    end
                end else begin
                    m_hold_left[k]--;
                end
            end else if (m_mode[k] == 2) begin
                old_fcw = m_fcw[k];
                if (old_fcw == 0) begin
                    m_ref_en[k] = 1; m_phase[k] = 0; m_acc[k] = 0;
                end else begin
                    s           = m_acc[k] + old_fcw;
                    m_ref_en[k] = (s >= MOD);
                    m_acc[k]    = s % MOD;
                    m_phase[k]  = (m_acc[k] >= MOD / 2);
                    if (m_ref_en[k] && m_pend[k]) begin
                        m_fcw[k]  = m_next[k];
                        m_pend[k] = 0;
                    end
                end
                if (hit) begin
                    if (old_fcw == 0) m_fcw[k] = fcw;
                    else begin
                        m_next[k] = fcw;
                        m_pend[k] = 1;
                    end
                end
            end
        end
    endfunction

    task automatic compare_all();
        logic [NCH-1:0]      e_rst, e_en, e_ph, e_run;
        logic [NCH*DW_W-1:0] e_dw;
        for (int k = 0; k < NCH; k++) begin
            e_rst[k] = (m_mode[k] != 2);
            e_run[k] = (m_mode[k] == 2);
            e_en[k]  = m_ref_en[k];
            e_ph[k]  = m_phase[k];
            e_dw[k*DW_W +: DW_W] = DW_W'(m_w[k]);
        end
        check("cmd_ready",     64'(cmd_ready),     64'(m_ready));
        check("cmd_err",       64'(cmd_err),       64'(m_err));
        check("channel_reset", 64'(channel_reset), 64'(e_rst));
        check("datawidth",     64'(datawidth),     64'(e_dw));
        check("ref_en",        64'(ref_en),        64'(e_en));
        check("ref_phase",     64'(ref_phase),     64'(e_ph));
        check("ch_running",    64'(ch_running),    64'(e_run));
    endtask

    // ---------------- stimulus helpers ----------------
    int cyc   = 0;
    int last1 = -1;
    int gaps[$];

    task automatic step(input bit v, input int ch, input int op, input int wa, input int wb, input int fcw);
        cmd_valid   = v;
        cmd_ch      = CH_W'(ch);
        cmd_op      = 2'(op);
        cmd_width_a = DW_W'(wa);
        cmd_width_b = DW_W'(wb);
        cmd_fcw     = ACC_W'(fcw);
        @(posedge clock);
        model_edge(v, ch, op, wa, wb, fcw);
        @(negedge clock);
        compare_all();
        cyc++;
        if (ref_en[1]) begin
            if (last1 >= 0) gaps.push_back(cyc - last1);
            last1 = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int min_gap;
        int ch, op, wa, wb, fcw, sel;
        bit v;

        // Reset values
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        check("rst_channel_reset", 64'(channel_reset), 64'(3'b111));
        check("rst_cmd_ready",     64'(cmd_ready),     64'(0));
        reset_n = 1'b1;
        idle(2);

        // 1: ch1 width 3, fcw 64 -> 4-cycle tick period
        step(1'b1, 1, 2, 3, 0, 64);
        idle(4);
        check("ch1_running_after_hold", 64'(ch_running[1]), 64'(1));
        check("ch1_datawidth",          64'(datawidth[5:3]), 64'(3));
        gaps.delete();
        idle(12);
        check("ch1_period_64", 64'((gaps.size() > 0) ? gaps[$] : 0), 64'(4));

        // 2: ch0 bypass
        step(1'b1, 0, 3, 0, 5, 0);
        idle(5);
        check("bypass_ref_en",    64'(ref_en[0]),      64'(1));
        check("bypass_ref_phase", 64'(ref_phase[0]),   64'(0));
        check("bypass_datawidth", 64'(datawidth[2:0]), 64'(5));

        // 3: glitch-free retune on ch1, 64 -> 32
        idle(2);
        gaps.delete();
        step(1'b1, 1, 2, 3, 0, 32);
        idle(30);
        min_gap = 1000;
        foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
        check("retune_min_gap_ok", 64'(min_gap >= 4),  64'(1));
        check("retune_new_period", 64'((gaps.size() > 0) ? gaps[$] : 0), 64'(8));
        check("retune_no_reset",   64'(channel_reset[1]), 64'(0));

        // 4: width change on running ch1 -> lane re-reset
        step(1'b1, 1, 3, 0, 6, 64);
        for (int i = 0; i < 3; i++) begin
            check("rewidth_hold_rst", 64'(channel_reset[1]), 64'(1));
            check("rewidth_hold_en",  64'(ref_en[1]),        64'(0));
            idle(1);
        end
        idle(1);
        check("rewidth_running",   64'(ch_running[1]),   64'(1));
        check("rewidth_datawidth", 64'(datawidth[5:3]), 64'(6));

        // 5: out-of-range channel, then RESET on unconfigured ch2
        step(1'b1, 3, 2, 1, 1, 64);
        check("err_pulse", 64'(cmd_err), 64'(1));
        idle(1);
        check("err_clear", 64'(cmd_err), 64'(0));
        step(1'b1, 2, 1, 0, 0, 0);
        idle(4);
        check("unconf_ch2_off", 64'(ch_running[2]),    64'(0));
        check("unconf_ch2_rst", 64'(channel_reset[2]), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ch  = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? 0 : (sel == 1) ? 1 : $urandom_range(2, 3);
            wa  = $urandom_range(0, 7);
            wb  = $urandom_range(0, 7);
            if (ch < NCH && $urandom_range(0, 1) == 1) begin
                if (op == 2) wa = m_w[ch];
                else         wb = m_w[ch];
            end
            case ($urandom_range(0, 4))
                0:       fcw = 0;
                1:       fcw = 32;
                2:       fcw = 64;
                3:       fcw = 128;
                default: fcw = $urandom_range(1, 255);
            endcase
            v = ($urandom_range(0, 2) == 0);
            step(v, ch, op, wa, wb, fcw);
        end

        // 6: asynchronous reset between clock edges while ch1 runs
        step(1'b1, 1, 2, 1, 0, 64);
        idle(6);
        check("pre_async_running", 64'(ch_running[1]), 64'(1));
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_channel_reset", 64'(channel_reset), 64'(3'b111));
        check("async_ref_en",        64'(ref_en),        64'(0));
        check("async_cmd_ready",     64'(cmd_ready),     64'(0));
        check("async_ch_running",    64'(ch_running),    64'(0));
        check("async_datawidth",     64'(datawidth),     64'(0));
        model_reset();
        @(negedge clock);
        compare_all();
        reset_n = 1'b1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
